// File: rtl/btn_cond_bank.sv
// rtl/btn_cond_bank.sv - bank of N_CH synchronised, debounced push-button conditioners with press/repeat/release pulses
module btn_cond_bank #(
  parameter int N_CH       = 5,
  parameter int DB_CYCLES  = 32768,
  parameter int RPT_DELAY  = 25_000_000,
  parameter int RPT_PERIOD = 5_000_000
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic [N_CH-1:0] pb,
  input  logic [N_CH-1:0] en,
  output logic [N_CH-1:0] dpb,
  output logic [N_CH-1:0] scen,
  output logic [N_CH-1:0] mcen,
  output logic [N_CH-1:0] rel
);

  localparam int MAX_AB = (DB_CYCLES > RPT_DELAY) ? DB_CYCLES : RPT_DELAY;
  localparam int MAX_C  = (MAX_AB > RPT_PERIOD) ? MAX_AB : RPT_PERIOD;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DB_LOAD  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LOAD = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] PER_LOAD = CW'(RPT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD_FIRST,
    HELD_RPT,
    REL_WAIT
  } state_t;

  logic [N_CH-1:0] sync1_q, sync2_q;

  // The synchroniser keeps running even while a channel is disabled.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pb;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dpb_q, dpb_d, scen_q, scen_d, mcen_q, mcen_d, rel_q, rel_d;
    logic          s, cnt_zero;

    assign s        = sync2_q[i];
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        dpb_q   <= 1'b0;
        scen_q  <= 1'b0;
        mcen_q  <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        dpb_q   <= dpb_d;
        scen_q  <= scen_d;
        mcen_q  <= mcen_d;
        rel_q   <= rel_d;
      end
    end

    // Release is tested before the counter so a repeat never fires on the release edge.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      scen_d  = 1'b0;
      mcen_d  = 1'b0;
      rel_d   = 1'b0;
      if (!en[i]) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (s) begin
              state_d = PRESS_WAIT;
              cnt_d   = DB_LOAD;
            end
          end
          PRESS_WAIT: begin
            if (!s) begin
              state_d = IDLE;
            end else if (cnt_zero) begin
              state_d = HELD_FIRST;
              cnt_d   = DLY_LOAD;
              scen_d  = 1'b1;
              mcen_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          HELD_FIRST, HELD_RPT: begin
            if (!s) begin
              state_d = REL_WAIT;
              cnt_d   = DB_LOAD;
            end else if (cnt_zero) begin
              state_d = HELD_RPT;
              cnt_d   = PER_LOAD;
              mcen_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          REL_WAIT: begin
            if (s) begin
              state_d = HELD_RPT;
              cnt_d   = PER_LOAD;
            end else if (cnt_zero) begin
              state_d = IDLE;
              rel_d   = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
      dpb_d = (state_d == HELD_FIRST) || (state_d == HELD_RPT) || (state_d == REL_WAIT);
    end

    assign dpb[i]  = dpb_q;
    assign scen[i] = scen_q;
    assign mcen[i] = mcen_q;
    assign rel[i]  = rel_q;
  end

endmodule

// File: tb/tb_btn_cond_bank.sv
// tb/tb_btn_cond_bank.sv - scoreboard bench for btn_cond_bank with directed scenarios and random bouncing buttons
module tb_btn_cond_bank;

  localparam int N  = 3;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [N-1:0] pb = '0;
  logic [N-1:0] en = '1;
  logic [N-1:0] dpb, scen, mcen, rel;

  btn_cond_bank #(
    .N_CH(N), .DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pb(pb), .en(en),
    .dpb(dpb), .scen(scen), .mcen(mcen), .rel(rel)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run lengths of the synchronised level and an absolute repeat deadline.
  logic [4*N-1:0] exp_q[$];
  int             m_run[N];
  bit             m_acc[N];
  longint         m_next[N];
  bit             m_s1[N], m_s2[N];
  longint         m_t;

  always @(posedge Clk or negedge Reset_n) begin
    logic [4*N-1:0] e;
    bit s;
    e = '0;
    if (!Reset_n) begin
      for (int c = 0; c < N; c++) begin
        m_run[c] = 0; m_acc[c] = 0; m_next[c] = 0; m_s1[c] = 0; m_s2[c] = 0;
      end
      m_t = 0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      m_t++;
      for (int c = 0; c < N; c++) begin
        s = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = pb[c];
        if (!en[c]) begin
          m_acc[c] = 0;
          m_run[c] = 0;
        end else if (!m_acc[c]) begin
          if (s) begin
            m_run[c]++;
            if (m_run[c] == DB + 1) begin
              m_acc[c] = 1; m_run[c] = 0;
              e[2*N+c] = 1'b1; e[N+c] = 1'b1;
              m_next[c] = m_t + RD;
            end
          end else begin
            m_run[c] = 0;
          end
        end else if (!s) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            m_acc[c] = 0; m_run[c] = 0;
            e[c] = 1'b1;
          end
        end else if (m_run[c] != 0) begin
          m_run[c] = 0;
          m_next[c] = m_t + RP;
        end else if (m_t == m_next[c]) begin
          e[N+c] = 1'b1;
          m_next[c] = m_t + RP;
        end
        e[3*N+c] = m_acc[c];
      end
      exp_q.push_back(e);
    end
  end

  always @(negedge Clk) begin
    logic [4*N-1:0] x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("scoreboard_outputs", 64'({dpb, scen, mcen, rel}), 64'(x));
    end
  end

  // Per-channel activity masks, bit k = output high just after edge k of the window.
  logic [63:0] r_dpb[N], r_scen[N], r_mcen[N], r_rel[N];
  int          rec_k;

  task automatic rec_start();
    for (int c = 0; c < N; c++) begin
      r_dpb[c] = '0; r_scen[c] = '0; r_mcen[c] = '0; r_rel[c] = '0;
    end
    rec_k = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    if (rec_k < 64) begin
      for (int c = 0; c < N; c++) begin
        r_dpb[c][rec_k]  = dpb[c];
        r_scen[c][rec_k] = scen[c];
        r_mcen[c][rec_k] = mcen[c];
        r_rel[c][rec_k]  = rel[c];
      end
    end
    rec_k++;
  endtask

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int b = lo; b <= hi; b++) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] b1(input int n);
    return 64'd1 << n;
  endfunction

  int hold_cnt[N];
  int en_off[N];

  initial begin
    rec_start();
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_outputs", 64'({dpb, scen, mcen, rel}), 64'd0);
    Reset_n = 1'b1;

    // Clean press on channel 0, held 40 samples
    rec_start();
    pb[0] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (k == 39) pb[0] = 1'b0;
    end
    chk("clean_scen", r_scen[0], b1(6));
    chk("clean_mcen", r_mcen[0] & span(0, 39), b1(6) | b1(16) | b1(21) | b1(26) | b1(31) | b1(36));
    chk("clean_rel", r_rel[0], b1(46));
    chk("clean_dpb", r_dpb[0], span(6, 45));

    // Bouncing press on channel 1
    rec_start();
    begin
      logic [7:0] pat;
      pat = 8'b1011_0111;
      for (int k = 0; k < 30; k++) begin
        pb[1] = (k < 8) ? pat[k] : 1'b1;
        step();
      end
    end
    chk("bounce_scen", r_scen[1], b1(13));
    chk("bounce_dpb", r_dpb[1], span(13, 29));
    pb[1] = 1'b0;
    repeat (15) step();

    // Release glitch on channel 0
    rec_start();
    pb[0] = 1'b1;
    for (int k = 0; k < 46; k++) begin
      step();
      if (k == 21) pb[0] = 1'b0;
      if (k == 23) pb[0] = 1'b1;
    end
    chk("glitch_scen", r_scen[0], b1(6));
    chk("glitch_rel", r_rel[0], 64'd0);
    chk("glitch_dpb", r_dpb[0], span(6, 45));
    chk("glitch_mcen", r_mcen[0], b1(6) | b1(16) | b1(21) | b1(31) | b1(36) | b1(41));

    // Asynchronous reset mid-hold
    repeat (4) step();
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_reset_clear", 64'({dpb, scen, mcen, rel}), 64'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    rec_start();
    repeat (20) step();
    chk("reset_rehold_scen", r_scen[0], b1(6));
    pb[0] = 1'b0;
    repeat (15) step();

    // Enable drop on channel 2 while held
    pb[2] = 1'b1;
    repeat (15) step();
    en[2] = 1'b0;
    step();
    chk("en_drop_dpb", 64'(dpb[2]), 64'd0);
    chk("en_drop_rel", 64'(rel[2]), 64'd0);
    en[2] = 1'b1;
    rec_start();
    repeat (10) step();
    chk("en_return_scen", r_scen[2], b1(4));
    chk("en_return_rel", r_rel[2], 64'd0);
    pb[2] = 1'b0;
    repeat (15) step();

    // Independence: channels 0 and 1 pressed together, released at different times
    rec_start();
    pb[0] = 1'b1;
    pb[1] = 1'b1;
    for (int k = 0; k < 46; k++) begin
      step();
      if (k == 19) pb[0] = 1'b0;
      if (k == 29) pb[1] = 1'b0;
    end
    chk("indep_scen0", r_scen[0], b1(6));
    chk("indep_scen1", r_scen[1], b1(6));
    chk("indep_mcen0", r_mcen[0], b1(6) | b1(16) | b1(21));
    chk("indep_mcen1", r_mcen[1], b1(6) | b1(16) | b1(21) | b1(26) | b1(31));
    chk("indep_rel0", r_rel[0], b1(26));
    chk("indep_rel1", r_rel[1], b1(36));
    chk("indep_ch2_quiet", r_dpb[2] | r_scen[2] | r_mcen[2] | r_rel[2], 64'd0);

    // Random bouncing buttons with occasional enable drops and one mid-cycle reset
    for (int c = 0; c < N; c++) begin
      hold_cnt[c] = 1;
      en_off[c] = 0;
    end
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        hold_cnt[c]--;
        if (hold_cnt[c] == 0) begin
          pb[c] = ~pb[c];
          hold_cnt[c] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 40));
        end
        if (en_off[c] > 0) begin
          en_off[c]--;
          en[c] = (en_off[c] == 0);
        end else if ($urandom_range(0, 99) == 0) begin
          en[c] = 1'b0;
          en_off[c] = $urandom_range(1, 2);
        end
      end
      if (i == 1500) begin
        #1;
        Reset_n = 1'b0;
        step();
        step();
        Reset_n = 1'b1;
      end
      step();
    end

    pb = '0;
    en = '1;
    repeat (20) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
